// File: rtl/ps2_pkg.sv
// Shared scan-code constants, decoder state encoding and key event record
// for the PS/2 keyboard controller.
package ps2_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  localparam int EVT_W = $bits(key_evt_t);

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Receiver-side and consumer-side signals of the PS/2 key controller.
// The slave modport is the controller; the master is whatever drives it.
interface ps2_key_ctrl_if;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       rd;
  logic       ovf_clr;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic       overflow;
  logic       err_tick;

  modport master (
    output rx_done_tick, rx_data, rd, ovf_clr,
    input  rx_en, key_valid, key_code, key_ext, key_brk, overflow, err_tick
  );

  modport slave (
    input  rx_done_tick, rx_data, rd, ovf_clr,
    output rx_en, key_valid, key_code, key_ext, key_brk, overflow, err_tick
  );
endinterface

// File: rtl/key_fifo.sv
// Show-ahead FIFO for decoded key events; a pop frees a slot for a push
// in the same cycle, and a push into a full FIFO without a pop is dropped.
module key_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & o_full & ~w_pop;
  // Head is forced to zero when empty so outputs are clean out of reset.
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into key events, buffers
// them in key_fifo, and abandons stalled prefix sequences after a timeout.
//   state       | meaning
//   ST_IDLE     | no prefix pending
//   ST_GOT_E0   | extended prefix seen
//   ST_GOT_F0   | break prefix seen
//   ST_GOT_E0F0 | extended break prefix seen
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input logic           clk,
  input logic           reset,
  ps2_key_ctrl_if.slave bus
);
  localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam int TMO_LAST_I = TIMEOUT_CYC - 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_LAST_I[TMO_W-1:0];

  ps2_state_t       r_state;
  ps2_state_t       w_state_src;
  ps2_state_t       w_state_nxt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err_tick;
  logic             r_overflow;
  logic             r_rx_en;
  logic             w_timeout;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  key_evt_t         w_evt;
  key_evt_t         w_head;
  logic [EVT_W-1:0] w_head_raw;

  // A timeout and a byte in the same cycle: the byte is decoded from IDLE.
  always_comb begin
    w_timeout   = (r_state != ST_IDLE) && (r_tmo_cnt == TMO_LAST);
    w_state_src = w_timeout ? ST_IDLE : r_state;
    w_state_nxt = w_state_src;
    w_push      = 1'b0;
    w_evt.ext   = 1'b0;
    w_evt.brk   = 1'b0;
    w_evt.code  = bus.rx_data;
    if (bus.rx_done_tick) begin
      case (w_state_src)
        ST_IDLE: begin
          if (bus.rx_data == SC_EXT)      w_state_nxt = ST_GOT_E0;
          else if (bus.rx_data == SC_BRK) w_state_nxt = ST_GOT_F0;
          else                            w_push = 1'b1;
        end
        ST_GOT_E0: begin
          if (bus.rx_data == SC_BRK)      w_state_nxt = ST_GOT_E0F0;
          else if (bus.rx_data == SC_EXT) w_state_nxt = ST_GOT_E0;
          else begin
            w_push      = 1'b1;
            w_evt.ext   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_GOT_F0: begin
          if (bus.rx_data == SC_BRK)      w_state_nxt = ST_GOT_F0;
          else if (bus.rx_data == SC_EXT) w_state_nxt = ST_GOT_E0;
          else begin
            w_push      = 1'b1;
            w_evt.brk   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_GOT_E0F0: begin
          w_state_nxt = ST_IDLE;
          if (bus.rx_data != SC_EXT && bus.rx_data != SC_BRK) begin
            w_push    = 1'b1;
            w_evt.ext = 1'b1;
            w_evt.brk = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_tmo_cnt  <= '0;
      r_err_tick <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_err_tick <= w_timeout;
      if (bus.rx_done_tick || w_state_src == ST_IDLE) r_tmo_cnt <= '0;
      else                                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_rx_en    <= 1'b0;
    end else begin
      if (w_drop)           r_overflow <= 1'b1;
      else if (bus.ovf_clr) r_overflow <= 1'b0;
      r_rx_en <= ~w_full;
    end
  end

  key_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (bus.rd),
    .i_din   (w_evt),
    .o_dout  (w_head_raw),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_drop  (w_drop)
  );

  assign w_head        = key_evt_t'(w_head_raw);
  assign bus.key_valid = ~w_empty;
  assign bus.key_code  = w_head.code;
  assign bus.key_ext   = w_head.ext;
  assign bus.key_brk   = w_head.brk;
  assign bus.overflow  = r_overflow;
  assign bus.err_tick  = r_err_tick;
  assign bus.rx_en     = r_rx_en;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: prefix decoding, timeout boundary,
// FIFO full/overflow behaviour and mid-sequence reset.
module tb_ps2_key_ctrl;
  localparam int TMO = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_err;

  ps2_key_ctrl_if bus ();

  ps2_key_ctrl #(
    .TIMEOUT_CYC (TMO),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] code, input logic ext, input logic brk);
    chk({tag, "_valid"}, {31'd0, bus.key_valid}, 32'd1);
    chk({tag, "_code"},  {24'd0, bus.key_code},  {24'd0, code});
    chk({tag, "_ext"},   {31'd0, bus.key_ext},   {31'd0, ext});
    chk({tag, "_brk"},   {31'd0, bus.key_brk},   {31'd0, brk});
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic count_err(input int ncyc, output int n);
    n = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (bus.err_tick === 1'b1) n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rd           = 1'b0;
    bus.ovf_clr      = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_valid",    {31'd0, bus.key_valid}, 32'd0);
    chk("rst_overflow", {31'd0, bus.overflow},  32'd0);
    chk("rst_err",      {31'd0, bus.err_tick},  32'd0);
    chk("rst_rx_en",    {31'd0, bus.rx_en},     32'd0);
    chk("rst_code",     {24'd0, bus.key_code},  32'd0);
    chk("rst_ext",      {31'd0, bus.key_ext},   32'd0);
    chk("rst_brk",      {31'd0, bus.key_brk},   32'd0);

    reset = 1'b1;
    @(negedge clk);
    chk("rel_rx_en", {31'd0, bus.rx_en}, 32'd1);

    // plain make code, key_valid one cycle after the tick
    chk("t1c_pre_valid", {31'd0, bus.key_valid}, 32'd0);
    send_byte(8'h1C);
    pop_chk("t1c", 8'h1C, 1'b0, 1'b0);
    chk("t1c_empty", {31'd0, bus.key_valid}, 32'd0);

    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h75);
    pop_chk("seq_brk",    8'h1C, 1'b0, 1'b1);
    pop_chk("seq_extbrk", 8'h75, 1'b1, 1'b1);
    pop_chk("seq_ext",    8'h75, 1'b1, 1'b0);
    chk("seq_empty", {31'd0, bus.key_valid}, 32'd0);

    // byte one cycle before the timeout still completes the prefix
    send_byte(8'hE0);
    count_err(TMO - 3, n_err);
    send_byte(8'h1C);
    chk("tmo_a_err", n_err + {31'd0, bus.err_tick}, 32'd0);
    pop_chk("tmo_a", 8'h1C, 1'b1, 1'b0);

    // byte in the timeout cycle is decoded from IDLE
    send_byte(8'hE0);
    count_err(TMO - 2, n_err);
    chk("tmo_b_early", n_err, 32'd0);
    send_byte(8'h1C);
    chk("tmo_b_err", {31'd0, bus.err_tick}, 32'd1);
    pop_chk("tmo_b", 8'h1C, 1'b0, 1'b0);

    // abandoned E0: single err pulse, no event
    send_byte(8'hE0);
    count_err(TMO + 10, n_err);
    chk("tmo_pulses", n_err, 32'd1);
    chk("tmo_noevt", {31'd0, bus.key_valid}, 32'd0);
    send_byte(8'h1C);
    pop_chk("tmo_after", 8'h1C, 1'b0, 1'b0);

    // rd while empty is ignored
    @(negedge clk); bus.rd = 1'b1;
    @(negedge clk); bus.rd = 1'b0;
    chk("rd_empty", {31'd0, bus.key_valid}, 32'd0);
    send_byte(8'h21);
    pop_chk("rd_empty_then", 8'h21, 1'b0, 1'b0);

    // fill, overflow, clear
    for (int i = 0; i < 4; i++) send_byte(8'(8'h11 + i));
    @(negedge clk);
    chk("full_rx_en", {31'd0, bus.rx_en}, 32'd0);
    chk("full_ovf0",  {31'd0, bus.overflow}, 32'd0);
    send_byte(8'h15);
    chk("ovf_set",  {31'd0, bus.overflow}, 32'd1);
    chk("ovf_head", {24'd0, bus.key_code}, 32'h11);
    @(negedge clk); bus.ovf_clr = 1'b1;
    @(negedge clk); bus.ovf_clr = 1'b0;
    chk("ovf_clr", {31'd0, bus.overflow}, 32'd0);

    // push and pop together while full
    @(negedge clk);
    bus.rx_data = 8'h16; bus.rx_done_tick = 1'b1; bus.rd = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0; bus.rd = 1'b0;
    chk("pp_ovf",   {31'd0, bus.overflow}, 32'd0);
    chk("pp_head",  {24'd0, bus.key_code}, 32'h12);
    chk("pp_rx_en", {31'd0, bus.rx_en},    32'd0);

    // drop and clear in the same cycle: drop wins
    @(negedge clk);
    bus.rx_data = 8'h17; bus.rx_done_tick = 1'b1; bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.rx_done_tick = 1'b0; bus.ovf_clr = 1'b0;
    chk("drop_wins", {31'd0, bus.overflow}, 32'd1);
    @(negedge clk); bus.ovf_clr = 1'b1;
    @(negedge clk); bus.ovf_clr = 1'b0;
    chk("drop_clr", {31'd0, bus.overflow}, 32'd0);

    pop_chk("drain0", 8'h12, 1'b0, 1'b0);
    pop_chk("drain1", 8'h13, 1'b0, 1'b0);
    pop_chk("drain2", 8'h14, 1'b0, 1'b0);
    pop_chk("drain3", 8'h16, 1'b0, 1'b0);
    chk("drain_empty", {31'd0, bus.key_valid}, 32'd0);
    chk("drain_rx_en", {31'd0, bus.rx_en},     32'd1);

    // reset mid-sequence with events queued
    send_byte(8'h31); send_byte(8'h32); send_byte(8'hF0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("mrst_valid", {31'd0, bus.key_valid}, 32'd0);
    chk("mrst_code",  {24'd0, bus.key_code},  32'd0);
    chk("mrst_rx_en", {31'd0, bus.rx_en},     32'd0);
    reset = 1'b1;
    @(negedge clk);
    send_byte(8'h1C);
    pop_chk("mrst_after", 8'h1C, 1'b0, 1'b0);
    chk("mrst_empty", {31'd0, bus.key_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
